// File: rtl/prbs_checker.sv
// Bit-serial PRBS checker: self-synchronises to an LFSR stream, then flywheels its own
// prediction to count bit errors and drops lock when the error density gets too high.
module prbs_checker #(
  parameter int unsigned       LENGTH      = 16,
  parameter logic [0:LENGTH-1] TAPS        = 16'b0110100000000001,
  parameter int unsigned       LOCK_CNT    = 32,
  parameter int unsigned       WINDOW      = 256,
  parameter int unsigned       LOSS_THRESH = 8,
  parameter int unsigned       ERR_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_cnt,
  output logic [ERR_WIDTH-1:0] bit_cnt
);

  localparam int unsigned FillW  = $clog2(LENGTH + 1);
  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WinW   = $clog2(WINDOW + 1);
  localparam int unsigned WerrW  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  state_e                state_q, state_d;
  logic [0:LENGTH-1]     h_q, h_d;
  logic [FillW-1:0]      fill_q, fill_d;
  logic [MatchW-1:0]     match_q, match_d;
  logic [WinW-1:0]       win_cnt_q, win_cnt_d;
  logic [WerrW-1:0]      win_err_q, win_err_d;
  logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [ERR_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  err_pulse_q, err_pulse_d;
  logic                  pred;
  logic                  mismatch;

  assign pred     = ^(h_q & TAPS);
  assign mismatch = bit_in ^ pred;

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    err_pulse_d = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        StSearch: begin
          h_d = {bit_in, h_q[0:LENGTH-2]};
          if (fill_q != FillW'(LENGTH)) begin
            fill_d = fill_q + FillW'(1);
          end else if (!mismatch && (h_q != '0)) begin
            if (match_q == MatchW'(LOCK_CNT - 1)) begin
              state_d = StLocked;
              match_d = '0;
            end else begin
              match_d = match_q + MatchW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        StLocked: begin
          // Flywheel: shift in our own prediction so one flipped bit counts once.
          h_d         = {pred, h_q[0:LENGTH-2]};
          err_pulse_d = mismatch;
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + ERR_WIDTH'(1);
          if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
          // Threshold is tested against the old window before any window rollover.
          if (mismatch && ((32'(win_err_q) + 32'd1) >= LOSS_THRESH)) begin
            state_d   = StSearch;
            fill_d    = '0;
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_q == WinW'(WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WinW'(1);
            win_err_d = win_err_q + WerrW'(mismatch);
          end
        end
        default: state_d = StSearch;
      endcase
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StSearch;
      h_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign bit_cnt   = bit_cnt_q;

endmodule
